// File: rtl/data_mem_ws.sv
// Byte-addressed little-endian data memory with a fixed number of wait states per access.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with err.
module data_mem_ws #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   logic [7:0]        mem [DEPTH];
   state_t            state;
   logic [3:0]        cnt;

   logic              lat_we;
   logic [2:0]        lat_op;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;

   logic              acc_we;
   logic [2:0]        acc_op;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       acc_wdata;
   logic [ADDR_W-1:0] a0, a1, a2, a3;
   size_t             acc_sz;
   logic              acc_sext;
   logic              acc_ok;
   logic [31:0]       rd_ext;
   logic [31:0]       acc_rdata;
   logic              acc_err;
   logic              done_next;

   // With zero wait states the access completes on its accept edge, so the live inputs stand in
   // for the latched copy there; in every other state only the latched copy is used.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      acc_we    = lat_we;
      acc_op    = lat_op;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      if (state == IDLE) begin
         acc_we    = we;
         acc_op    = op;
         acc_addr  = addr;
         acc_wdata = wdata;
      end
   end

   always_comb begin
      acc_ok   = 1'b1;
      acc_sz   = SZ_B;
      acc_sext = ~acc_op[2];
      case (acc_op)
         3'b000, 3'b100: acc_sz = SZ_B;
         3'b001, 3'b101: acc_sz = SZ_H;
         3'b010:         acc_sz = SZ_W;
         default:        acc_ok = 1'b0;
      endcase
`ifdef DMEM_ALIGN_CHECK_EN
      if ((acc_sz == SZ_H && acc_addr[0]) || (acc_sz == SZ_W && acc_addr[1:0] != 2'b00))
         acc_ok = 1'b0;
`endif
   end

   // Byte lanes wrap around the top of the address space.
   assign a0 = acc_addr;
   assign a1 = acc_addr + ADDR_W'(1);
   assign a2 = acc_addr + ADDR_W'(2);
   assign a3 = acc_addr + ADDR_W'(3);

   always_comb begin
      rd_ext = '0;
      case (acc_sz)
         SZ_B:    rd_ext = {{24{acc_sext & mem[a0][7]}}, mem[a0]};
         SZ_H:    rd_ext = {{16{acc_sext & mem[a1][7]}}, mem[a1], mem[a0]};
         default: rd_ext = {mem[a3], mem[a2], mem[a1], mem[a0]};
      endcase
   end

   assign acc_rdata = (acc_ok && !acc_we) ? rd_ext : 32'h0;
   assign acc_err   = ~acc_ok;
   assign done_next = (state == IDLE && req && WAIT_CYCLES == 0) ||
                      (state == WAIT && cnt == 4'd1);

   // NOTE: the array is cleared by reset on purpose, so it maps to flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else if (done_next && acc_we && acc_ok) begin
         mem[a0] <= acc_wdata[7:0];
         if (acc_sz != SZ_B) mem[a1] <= acc_wdata[15:8];
         if (acc_sz == SZ_W) begin
            mem[a2] <= acc_wdata[23:16];
            mem[a3] <= acc_wdata[31:24];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         busy      <= 1'b0;
         ready     <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'h0;
         lat_we    <= 1'b0;
         lat_op    <= 3'b000;
         lat_addr  <= '0;
         lat_wdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               err   <= 1'b0;
               if (req) begin
                  lat_we    <= we;
                  lat_op    <= op;
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  busy      <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state <= DONE;
                     ready <= 1'b1;
                     err   <= acc_err;
                     rdata <= acc_rdata;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_CYCLES);
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state <= DONE;
                  ready <= 1'b1;
                  err   <= acc_err;
                  rdata <= acc_rdata;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               ready <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

endmodule
